// File: rtl/inv_linear_trans_spn32_serial.sv
`default_nettype none
// ============================================================================
// Module   : inv_linear_trans_spn32_serial (+ mult_2_GF32, mult_4_GF32)
// Brief    : Word-serial inverse SPN32 diffusion layer. It gathers four
//            32-bit words, then streams out four words of b = M*a. M is an
//            involution over GF(2^32).
// Revision : 1.0 - initial release
// ============================================================================

module mult_2_GF32 #(
  parameter logic [31:0] POLY = 32'h0040_0007
) (
  input  logic [31:0] i_a,
  output logic [31:0] o_y
);
  // x * a, reduced by x^32 + x^22 + x^2 + x + 1
  assign o_y = {i_a[30:0], 1'b0} ^ (i_a[31] ? POLY : 32'h0);
endmodule

module mult_4_GF32 #(
  parameter logic [31:0] POLY = 32'h0040_0007
) (
  input  logic [31:0] i_a,
  output logic [31:0] o_y
);
  logic [31:0] w_x1;
  assign w_x1 = {i_a[30:0], 1'b0} ^ (i_a[31] ? POLY : 32'h0);
  assign o_y  = {w_x1[30:0], 1'b0} ^ (w_x1[31] ? POLY : 32'h0);
endmodule

module inv_linear_trans_spn32_serial #(
  parameter bit LSW_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy
);

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_nxt;
  logic        r_run;
  logic [31:0] r_a [4];

  logic [1:0]  w_idx;
  logic        w_in_fire;
  logic        w_out_fire;
  logic [31:0] w_s;
  logic [31:0] w_t;
  logic [31:0] w_xs;
  logic [31:0] w_x2t;
  logic [31:0] w_b;

  // The same word index serves the load slot and the output word k.
  assign w_idx      = LSW_FIRST ? r_cnt : (2'd3 - r_cnt);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_data    = 32'h0;
    case (r_state)
      LOAD: begin
        in_ready = r_run;
        if (w_in_fire) begin
          w_cnt_nxt = r_cnt + 2'd1;
          if (r_cnt == 2'd3) w_state_nxt = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = (r_cnt == 2'd3);
        out_data  = w_b;
        if (w_out_fire) begin
          w_cnt_nxt = r_cnt + 2'd1;
          if (r_cnt == 2'd3) w_state_nxt = LOAD;
        end
      end
      default: begin
        w_state_nxt = LOAD;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  // r_run keeps in_ready low until the first edge after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOAD;
      r_cnt   <= 2'd0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_run   <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_a[i] <= 32'h0;
    end else if (w_in_fire) begin
      r_a[w_idx] <= in_data;
    end
  end

  // Odd k pairs x with a0^a2, upper k pairs x^2 with a0^a1.
  assign w_s = w_idx[0] ? (r_a[0] ^ r_a[2]) : (r_a[1] ^ r_a[3]);
  assign w_t = w_idx[1] ? (r_a[0] ^ r_a[1]) : (r_a[2] ^ r_a[3]);

  mult_2_GF32 u_mult_2 (
    .i_a (w_s),
    .o_y (w_xs)
  );

  mult_4_GF32 u_mult_4 (
    .i_a (w_t),
    .o_y (w_x2t)
  );

  assign w_b  = r_a[w_idx] ^ w_xs ^ w_x2t;
  assign busy = !((r_state == LOAD) && (r_cnt == 2'd0));

endmodule

`default_nettype wire

// File: tb/tb_inv_linear_trans_spn32_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_linear_trans_spn32_serial
// Brief    : Self-checking bench driving LSW_FIRST=1 and LSW_FIRST=0 instances
//            in lockstep against a GF(2^32) matrix model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_inv_linear_trans_spn32_serial;

  localparam logic [31:0] C_POLY = 32'h0040_0007;

  typedef logic [3:0][31:0] blk_t;
  typedef struct packed {
    blk_t w;
    blk_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        out_ready = 1'b0;

  logic        in_ready1, out_valid1, out_last1, busy1;
  logic [31:0] out_data1;
  logic        in_ready0, out_valid0, out_last0, busy0;
  logic [31:0] out_data0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inv_linear_trans_spn32_serial #(.LSW_FIRST(1'b1)) u_dut_lsw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_last(out_last1), .busy(busy1)
  );

  inv_linear_trans_spn32_serial #(.LSW_FIRST(1'b0)) u_dut_msw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_last(out_last0), .busy(busy0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] gf_mul(input logic [31:0] c, input logic [31:0] a);
    logic [31:0] acc;
    logic [31:0] p;
    acc = 32'h0;
    p   = a;
    for (int i = 0; i < 32; i++) begin
      if (c[i]) acc ^= p;
      p = p[31] ? ((p << 1) ^ C_POLY) : (p << 1);
    end
    return acc;
  endfunction

  // M = [[A,B],[B,A]], A = [[1,x],[x,1]], B = [[x^2,x+x^2],[x+x^2,x^2]]
  function automatic logic [31:0] coef(input int i, input int j);
    bit same_blk;
    bit diag;
    same_blk = ((i / 2) == (j / 2));
    diag     = ((i % 2) == (j % 2));
    if (same_blk) return diag ? 32'h1 : 32'h2;
    return diag ? 32'h4 : 32'h6;
  endfunction

  function automatic blk_t model(input blk_t w, input bit lsw);
    blk_t a;
    blk_t b;
    blk_t o;
    for (int j = 0; j < 4; j++) a[j] = lsw ? w[j] : w[3-j];
    for (int i = 0; i < 4; i++) begin
      b[i] = 32'h0;
      for (int j = 0; j < 4; j++) b[i] ^= gf_mul(coef(i, j), a[j]);
    end
    for (int k = 0; k < 4; k++) o[k] = lsw ? b[k] : b[3-k];
    return o;
  endfunction

  function automatic blk_t mk(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
    blk_t r;
    r[0] = w0; r[1] = w1; r[2] = w2; r[3] = w3;
    return r;
  endfunction

  task automatic send_word(input logic [31:0] d, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready1) chk("in_ready_timeout", {31'h0, in_ready1}, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic recv_word(input logic [31:0] e1, input logic [31:0] e0,
                           input logic lst, input int stall);
    int n;
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      chk("stall_data", out_data1, e1);
      chk("stall_last", {31'h0, out_last1}, {31'h0, lst});
      chk("stall_in_ready", {31'h0, in_ready1}, 32'h0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (!out_valid1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid", {31'h0, out_valid1}, 32'h1);
    chk("out_data_lsw", out_data1, e1);
    chk("out_data_msw", out_data0, e0);
    chk("out_last_lsw", {31'h0, out_last1}, {31'h0, lst});
    chk("out_last_msw", {31'h0, out_last0}, {31'h0, lst});
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_block(input blk_t w, input blk_t e1, input blk_t e0,
                           input int gap_max, input int stall_max);
    for (int i = 0; i < 4; i++) send_word(w[i], $urandom_range(0, gap_max));
    chk("latency_valid", {31'h0, out_valid1}, 32'h1);
    for (int k = 0; k < 4; k++)
      recv_word(e1[k], e0[k], (k == 3), $urandom_range(0, stall_max));
    chk("post_in_ready", {31'h0, in_ready1}, 32'h1);
    chk("post_out_data", out_data1, 32'h0);
    chk("post_busy", {31'h0, busy1}, 32'h0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t tab [5];

  initial begin
    blk_t a;
    blk_t b;
    tab[0] = '{w: mk(32'h1, 32'h0, 32'h0, 32'h0), e: mk(32'h1, 32'h2, 32'h4, 32'h6)};
    tab[1] = '{w: mk(32'h0, 32'h1, 32'h0, 32'h0), e: mk(32'h2, 32'h1, 32'h6, 32'h4)};
    tab[2] = '{w: mk(32'h0, 32'h0, 32'h0, 32'h0), e: mk(32'h0, 32'h0, 32'h0, 32'h0)};
    tab[3] = '{w: mk(32'h0, 32'h0, 32'h0, 32'h1), e: mk(32'h6, 32'h4, 32'h2, 32'h1)};
    tab[4] = '{w: mk(32'h0, 32'h0, 32'h1, 32'h0), e: mk(32'h4, 32'h6, 32'h1, 32'h2)};

    // reset values, observed while rst is held
    #1;
    chk("rst_in_ready", {31'h0, in_ready1}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid1}, 32'h0);
    chk("rst_out_data", out_data1, 32'h0);
    chk("rst_out_last", {31'h0, out_last1}, 32'h0);
    chk("rst_busy", {31'h0, busy1}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rel_in_ready_low", {31'h0, in_ready1}, 32'h0);
    @(posedge clk); #1;
    chk("rel_in_ready_high", {31'h0, in_ready1}, 32'h1);

    for (int v = 0; v < 5; v++) run_block(tab[v].w, tab[v].e, tab[v].e, 0, 0);

    // backpressure: five stalled cycles on k=1 of the first column
    for (int i = 0; i < 4; i++) send_word(tab[0].w[i], 0);
    recv_word(32'h1, 32'h1, 1'b0, 0);
    recv_word(32'h2, 32'h2, 1'b0, 5);
    recv_word(32'h4, 32'h4, 1'b0, 0);
    recv_word(32'h6, 32'h6, 1'b1, 0);
    chk("bp_in_ready", {31'h0, in_ready1}, 32'h1);

    // partial fill waits, busy stays high
    send_word(32'h0, 0);
    send_word(32'h1, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("partial_busy", {31'h0, busy1}, 32'h1);
    chk("partial_out_valid", {31'h0, out_valid1}, 32'h0);
    send_word(32'h0, 2);
    send_word(32'h0, 3);
    for (int k = 0; k < 4; k++) recv_word(tab[1].e[k], tab[1].e[k], (k == 3), 1);

    // async reset mid-LOAD
    send_word(32'hDEAD_BEEF, 0);
    send_word(32'h1234_5678, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_load_in_ready", {31'h0, in_ready1}, 32'h0);
    chk("arst_load_busy", {31'h0, busy1}, 32'h0);
    chk("arst_load_busy_msw", {31'h0, busy0}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_load_ready_back", {31'h0, in_ready1}, 32'h1);
    run_block(tab[1].w, tab[1].e, tab[1].e, 1, 1);

    // async reset mid-SEND at k=2
    for (int i = 0; i < 4; i++) send_word(tab[0].w[i], 0);
    recv_word(32'h1, 32'h1, 1'b0, 0);
    recv_word(32'h2, 32'h2, 1'b0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_send_valid", {31'h0, out_valid1}, 32'h0);
    chk("arst_send_data", out_data1, 32'h0);
    chk("arst_send_last", {31'h0, out_last1}, 32'h0);
    chk("arst_send_in_ready", {31'h0, in_ready1}, 32'h0);
    chk("arst_send_valid_msw", {31'h0, out_valid0}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_send_ready_back", {31'h0, in_ready1}, 32'h1);
    chk("arst_send_no_valid", {31'h0, out_valid1}, 32'h0);
    run_block(tab[3].w, tab[3].e, tab[3].e, 0, 0);

    // involution over random blocks with random gaps and stalls
    for (int r = 0; r < 500; r++) begin
      for (int i = 0; i < 4; i++) a[i] = $urandom;
      b = model(a, 1'b1);
      run_block(a, b, model(a, 1'b0), 2, 2);
      run_block(b, a, model(b, 1'b0), 2, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
